// File: rtl/bidir_pkg.sv
// Shared types and constants for the bidirectional bus transceiver.
// Gap counter sizing and parameter sanity helpers live here.
package bidir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AB   = 2'd1,
    BA   = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int GAP_W   = 4;
  localparam int GAP_MAX = (1 << GAP_W) - 1;

  // Legal turnaround lengths fit the gap counter and are non-zero
  function automatic bit gap_ok(input int g);
    return (g >= 1) && (g <= GAP_MAX);
  endfunction

endpackage

// File: rtl/tri_lane.sv
// One side of the transceiver: tri-state driver plus receive tap.
// Released lanes float so the far bus owner can drive them.
module tri_lane #(
  parameter int WIDTH = 8
) (
  inout  wire logic [WIDTH-1:0] io,
  input  logic                  oe,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      rx
);

  assign io = oe ? d : {WIDTH{1'bz}};
  assign rx = io;

endmodule

// File: rtl/bidir_xcvr.sv
// Registered bidirectional transceiver between buses a and b.
// Direction reversals pass through a dead gap with both sides released.
module bidir_xcvr
  import bidir_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire logic [WIDTH-1:0] a,
  inout  wire logic [WIDTH-1:0] b,
  input  logic                 en,
  input  logic                 dir,
  output logic                 drv_ab,
  output logic                 drv_ba,
  output logic                 busy,
  output logic [CNT_W-1:0]     rev_cnt
);

  if (!gap_ok(GAP_CYC)) begin : g_bad_gap
    $error("bidir_xcvr: GAP_CYC out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("bidir_xcvr: CNT_W must be at least 1");
  end

  localparam logic [GAP_W-1:0] GapLoad = GAP_W'(GAP_CYC - 1);

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q;
  logic               pre_ab_q;
  logic [CNT_W-1:0]   rev_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   a_rx, b_rx;
  logic               oe_a, oe_b;
  logic               gap_enter, rev_inc;

  tri_lane #(.WIDTH(WIDTH)) u_lane_a (
    .io (a),
    .oe (oe_a),
    .d  (q_q),
    .rx (a_rx)
  );

  tri_lane #(.WIDTH(WIDTH)) u_lane_b (
    .io (b),
    .oe (oe_b),
    .d  (q_q),
    .rx (b_rx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: reversals detour via GAP, en=0 drops straight to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = dir ? AB : BA;
      AB: begin
        if (!en)      state_d = IDLE;
        else if (!dir) state_d = GAP;
      end
      BA: begin
        if (!en)     state_d = IDLE;
        else if (dir) state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) begin
          if (!en) state_d = IDLE;
          else     state_d = dir ? AB : BA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    oe_a   = 1'b0;
    oe_b   = 1'b0;
    drv_ab = 1'b0;
    drv_ba = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      AB:      begin oe_b = 1'b1; drv_ab = 1'b1; end
      BA:      begin oe_a = 1'b1; drv_ba = 1'b1; end
      GAP:     busy = 1'b1;
      default: ;
    endcase
  end

  assign gap_enter = (state_d == GAP) && (state_q != GAP);
  assign rev_inc   = (state_q == GAP)
                   && ((state_d == AB) || (state_d == BA))
                   && ((state_d == AB) != pre_ab_q);

  // Gap counter and the direction held before the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q    <= '0;
      pre_ab_q <= 1'b0;
    end else if (gap_enter) begin
      gap_q    <= GapLoad;
      pre_ab_q <= (state_q == AB);
    end else if (state_q == GAP && gap_q != '0) begin
      gap_q    <= gap_q - 1'b1;
    end
  end

  // Saturating count of completed direction changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rev_q <= '0;
    else if (rev_inc && rev_q != '1) rev_q <= rev_q + 1'b1;
  end

  assign rev_cnt = rev_q;

  // Data register samples whichever side will be the source next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              q_q <= '0;
    else if (state_d == AB)  q_q <= a_rx;
    else if (state_d == BA)  q_q <= b_rx;
  end

endmodule

// File: tb/tb_bidir_xcvr.sv
// Self-checking bench for bidir_xcvr: vector table, scoreboard queue,
// async reset and counter saturation sequences.
module tb_bidir_xcvr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       a_oe = 1'b0, b_oe = 1'b0;
  logic [7:0] a_drv = '0, b_drv = '0;
  wire  [7:0] a, b;
  logic       drv_ab, drv_ba, busy;
  logic [7:0] rev_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;

  assign a = a_oe ? a_drv : 8'hzz;
  assign b = b_oe ? b_drv : 8'hzz;

  bidir_xcvr #(.WIDTH(8), .GAP_CYC(2), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .en      (en),
    .dir     (dir),
    .drv_ab  (drv_ab),
    .drv_ba  (drv_ba),
    .busy    (busy),
    .rev_cnt (rev_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && ((drv_ab && drv_ba) || (busy && (drv_ab || drv_ba))))
      viol++;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: act=%0h req=%0h", nm, act, req);
  endtask

  typedef struct {
    logic       en, dir;
    logic       a_oe;
    logic [7:0] a_v;
    logic       b_oe;
    logic [7:0] b_v;
    logic       ab, ba, bz;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic d,
                              input logic ao, input logic [7:0] av,
                              input logic bo, input logic [7:0] bv,
                              input logic xab, input logic xba,
                              input logic xbz, input int c);
    vec_t v;
    v.en = e; v.dir = d; v.a_oe = ao; v.a_v = av;
    v.b_oe = bo; v.b_v = bv; v.ab = xab; v.ba = xba;
    v.bz = xbz; v.cnt = c;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t       tv [NV];
  logic [7:0] sb [$];
  logic [7:0] exp_d;
  int         exp_cnt;

  initial begin
    tv[0]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 1, 8'hA5, 0, 8'h00, 1, 0, 0, 0);
    tv[2]  = mk(1, 1, 1, 8'h3C, 0, 8'h00, 1, 0, 0, 0);
    tv[3]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    tv[4]  = mk(1, 0, 0, 8'h00, 1, 8'h5A, 0, 0, 1, 0);
    tv[5]  = mk(1, 0, 0, 8'h00, 1, 8'h5A, 0, 1, 0, 1);
    tv[6]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1);
    tv[7]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1);
    tv[8]  = mk(1, 1, 1, 8'h11, 0, 8'h00, 1, 0, 0, 2);
    tv[9]  = mk(1, 0, 1, 8'h22, 0, 8'h00, 0, 0, 1, 2);
    tv[10] = mk(1, 1, 1, 8'h22, 0, 8'h00, 0, 0, 1, 2);
    tv[11] = mk(1, 1, 1, 8'h33, 0, 8'h00, 1, 0, 0, 2);
    tv[12] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2);
    tv[13] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2);
    tv[14] = mk(1, 0, 0, 8'h00, 1, 8'h77, 0, 1, 0, 2);
    tv[15] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2);
    tv[16] = mk(1, 1, 1, 8'h44, 0, 8'h00, 1, 0, 0, 2);
    tv[17] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 2);
    tv[18] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 2);
    tv[19] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2);

    // reset state
    #1;
    chk("rst_drv_ab", drv_ab, 0);
    chk("rst_drv_ba", drv_ba, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", rev_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < NV; i++) begin
      en = tv[i].en;  dir = tv[i].dir;
      a_oe = tv[i].a_oe; a_drv = tv[i].a_v;
      b_oe = tv[i].b_oe; b_drv = tv[i].b_v;
      if (tv[i].ab) sb.push_back(tv[i].a_v);
      if (tv[i].ba) sb.push_back(tv[i].b_v);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_drv_ab", i), drv_ab, tv[i].ab);
      chk($sformatf("v%0d_drv_ba", i), drv_ba, tv[i].ba);
      chk($sformatf("v%0d_busy", i), busy, tv[i].bz);
      chk($sformatf("v%0d_cnt", i), rev_cnt, tv[i].cnt);
      if (tv[i].ab || tv[i].ba) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", i), 1, 0);
        end else begin
          exp_d = sb.pop_front();
          if (tv[i].ab) chk($sformatf("v%0d_b_data", i), b, exp_d);
          else          chk($sformatf("v%0d_a_data", i), a, exp_d);
        end
      end
    end
    chk("sb_drained", sb.size(), 0);

    // async reset mid-BA
    en = 1'b1; dir = 1'b0; b_oe = 1'b1; b_drv = 8'h5A;
    @(posedge clk);
    #1;
    chk("pre_rst_ba", drv_ba, 1);
    chk("pre_rst_a", a, 8'h5A);
    chk("pre_rst_cnt", rev_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drv_ba", drv_ba, 0);
    chk("arst_drv_ab", drv_ab, 0);
    chk("arst_cnt", rev_cnt, 0);
    @(negedge clk);
    en = 1'b0; b_oe = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {drv_ab, drv_ba, busy}, 0);

    // saturation: 260 reversals
    en = 1'b1; dir = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_start_ab", drv_ab, 1);
    exp_cnt = 0;
    for (int r = 1; r <= 260; r++) begin
      dir = r[0] ? 1'b0 : 1'b1;
      repeat (3) @(posedge clk);
      #1;
      if (exp_cnt < 255) exp_cnt++;
      if (r == 1 || r == 254 || r == 255 || r == 256 || r == 260)
        chk($sformatf("sat_cnt_r%0d", r), rev_cnt, exp_cnt);
    end
    chk("sat_final_ab", drv_ab, 1);
    chk("sat_final_ff", rev_cnt, 8'hFF);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("mutex_viol", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
